// File: rtl/weighted_voter_if.sv
// Bundle of session control, vote inputs and tally outputs shared between
// the weighted voter and whoever drives it.
interface weighted_voter_if #(
    parameter int NP_N   = 32,
    parameter int VIP_N  = 8,
    parameter int VVIP_N = 1,
    parameter int RES_W  = 8
);
    localparam int CW = $clog2(NP_N + VIP_N + VVIP_N + 1);

    logic              start;
    logic              close;
    logic [NP_N-1:0]   np;
    logic [VIP_N-1:0]  vip;
    logic [VVIP_N-1:0] vvip;
    logic [RES_W-1:0]  threshold;
    logic [RES_W-1:0]  result;
    logic [CW-1:0]     voters;
    logic              open;
    logic              pass;
    logic              sat;

    modport master (
        output start, close, np, vip, vvip, threshold,
        input  result, voters, open, pass, sat
    );

    modport slave (
        input  start, close, np, vip, vvip, threshold,
        output result, voters, open, pass, sat
    );
endinterface

// File: rtl/weighted_voter.sv
// Session-based weighted vote tally: each voter counts once per session,
// the tally saturates with a sticky flag, and pass is decided after close.
module weighted_voter #(
    parameter int NP_N   = 32,
    parameter int VIP_N  = 8,
    parameter int VVIP_N = 1,
    parameter int W_NP   = 1,
    parameter int W_VIP  = 4,
    parameter int W_VVIP = 16,
    parameter int RES_W  = 8
) (
    input  logic           clk,
    input  logic           reset,
    weighted_voter_if.slave bus
);
    localparam int CW      = $clog2(NP_N + VIP_N + VVIP_N + 1);
    localparam int INC_MAX = W_NP * NP_N + W_VIP * VIP_N + W_VVIP * VVIP_N;
    localparam int IW      = $clog2(INC_MAX + 1);
    localparam int SW      = ((RES_W > IW) ? RES_W : IW) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_CLOSED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [CW-1:0]     voters_q, voters_d;
    logic              sat_q, sat_d;
    logic              open_q, open_d;
    logic [NP_N-1:0]   rec_np_q, rec_np_d;
    logic [VIP_N-1:0]  rec_vip_q, rec_vip_d;
    logic [VVIP_N-1:0] rec_vvip_q, rec_vvip_d;

    logic [NP_N-1:0]   new_np_s;
    logic [VIP_N-1:0]  new_vip_s;
    logic [VVIP_N-1:0] new_vvip_s;
    logic [CW-1:0]     cnt_np_s, cnt_vip_s, cnt_vvip_s;
    logic [IW-1:0]     inc_s;
    logic [SW-1:0]     sum_s;
    logic [SW-1:0]     res_max_s;

    // New-vote detection, per-class popcounts and the weighted increment.
    always_comb begin
        new_np_s   = bus.np & ~rec_np_q;
        new_vip_s  = bus.vip & ~rec_vip_q;
        new_vvip_s = bus.vvip & ~rec_vvip_q;
        cnt_np_s   = {CW{1'b0}};
        cnt_vip_s  = {CW{1'b0}};
        cnt_vvip_s = {CW{1'b0}};
        for (int i = 0; i < NP_N; i++) begin
            cnt_np_s = cnt_np_s + CW'(new_np_s[i]);
        end
        for (int i = 0; i < VIP_N; i++) begin
            cnt_vip_s = cnt_vip_s + CW'(new_vip_s[i]);
        end
        for (int i = 0; i < VVIP_N; i++) begin
            cnt_vvip_s = cnt_vvip_s + CW'(new_vvip_s[i]);
        end
        inc_s = IW'(W_NP) * IW'(cnt_np_s)
              + IW'(W_VIP) * IW'(cnt_vip_s)
              + IW'(W_VVIP) * IW'(cnt_vvip_s);
        sum_s     = SW'(result_q) + SW'(inc_s);
        res_max_s = {{(SW - RES_W){1'b0}}, {RES_W{1'b1}}};
    end

    // Next-state and next-tally logic; start always wins over close.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        voters_d   = voters_q;
        sat_d      = sat_q;
        rec_np_d   = rec_np_q;
        rec_vip_d  = rec_vip_q;
        rec_vvip_d = rec_vvip_q;
        case (state_q)
            ST_IDLE, ST_CLOSED: begin
                if (bus.start) begin
                    state_d    = ST_OPEN;
                    result_d   = {RES_W{1'b0}};
                    voters_d   = {CW{1'b0}};
                    sat_d      = 1'b0;
                    rec_np_d   = {NP_N{1'b0}};
                    rec_vip_d  = {VIP_N{1'b0}};
                    rec_vvip_d = {VVIP_N{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_OPEN: begin
                if (bus.start) begin
                    state_d    = ST_OPEN;
                    result_d   = {RES_W{1'b0}};
                    voters_d   = {CW{1'b0}};
                    sat_d      = 1'b0;
                    rec_np_d   = {NP_N{1'b0}};
                    rec_vip_d  = {VIP_N{1'b0}};
                    rec_vvip_d = {VVIP_N{1'b0}};
                end else begin
                    // Votes on the closing edge still count.
                    rec_np_d   = rec_np_q | new_np_s;
                    rec_vip_d  = rec_vip_q | new_vip_s;
                    rec_vvip_d = rec_vvip_q | new_vvip_s;
                    voters_d   = voters_q + cnt_np_s + cnt_vip_s + cnt_vvip_s;
                    if (sum_s > res_max_s) begin
                        result_d = {RES_W{1'b1}};
                        sat_d    = 1'b1;
                    end else begin
                        result_d = sum_s[RES_W-1:0];
                    end
                    if (bus.close) begin
                        state_d = ST_CLOSED;
                    end else begin
                        state_d = ST_OPEN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        open_d = (state_d == ST_OPEN);
    end

    // State, tally and voter-record registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            result_q   <= {RES_W{1'b0}};
            voters_q   <= {CW{1'b0}};
            sat_q      <= 1'b0;
            open_q     <= 1'b0;
            rec_np_q   <= {NP_N{1'b0}};
            rec_vip_q  <= {VIP_N{1'b0}};
            rec_vvip_q <= {VVIP_N{1'b0}};
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            voters_q   <= voters_d;
            sat_q      <= sat_d;
            open_q     <= open_d;
            rec_np_q   <= rec_np_d;
            rec_vip_q  <= rec_vip_d;
            rec_vvip_q <= rec_vvip_d;
        end
    end

    assign bus.result = result_q;
    assign bus.voters = voters_q;
    assign bus.sat    = sat_q;
    assign bus.open   = open_q;
    // pass follows the live threshold, so it is decoded rather than stored.
    assign bus.pass   = (state_q == ST_CLOSED) && (result_q >= bus.threshold);
endmodule
